// File: rtl/wb_lfsr_pkg.sv
// ============================================================================
//  Module      : wb_lfsr_pkg
//  Description : Shared types and constants for the wb_lfsr sequencer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_lfsr_pkg;

    localparam int WB_ADDR_W = 3;
    localparam int WB_DATA_W = 8;

    localparam logic [WB_ADDR_W-1:0] ADDR_CTRL_DEF    = 3'd0;
    localparam logic [WB_ADDR_W-1:0] ADDR_SEED_LO_DEF = 3'd1;
    localparam logic [WB_ADDR_W-1:0] ADDR_SEED_HI_DEF = 3'd2;
    localparam logic [WB_ADDR_W-1:0] ADDR_TAPS_LO_DEF = 3'd3;
    localparam logic [WB_ADDR_W-1:0] ADDR_TAPS_HI_DEF = 3'd4;
    localparam logic [WB_ADDR_W-1:0] ADDR_OUT_DEF     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_RD    = 3'd2,
        ST_EMIT  = 3'd3,
        ST_FIN   = 3'd4,
        ST_ABORT = 3'd5
    } state_e;

    // Bits arrive oldest-first, so the first one read lands in the MSB.
    function automatic logic [7:0] shift_in_msb(input logic [7:0] b, input logic din);
        return {b[6:0], din};
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_single_master.sv
// ============================================================================
//  Module      : wb_single_master
//  Description : Single-transaction pipelined Wishbone master with timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_single_master
    import wb_lfsr_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [WB_ADDR_W-1:0] i_addr,
    input  logic [WB_DATA_W-1:0] i_data,
    output logic                 o_done,
    output logic                 o_timeout,
    output logic                 o_rdata,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [WB_ADDR_W-1:0] o_wb_addr,
    output logic [WB_DATA_W-1:0] o_wb_data,
    input  logic                 i_wb_stall,
    input  logic                 i_wb_data,
    input  logic                 i_wb_ack
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic                 cyc_q,  cyc_d;
    logic                 stb_q,  stb_d;
    logic                 we_q,   we_d;
    logic [WB_ADDR_W-1:0] addr_q, addr_d;
    logic [WB_DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]     cnt_q,  cnt_d;

    logic w_ack;
    logic w_expire;

    // Acks outside a cycle are ignored; an ack on the last allowed cycle still wins.
    assign w_ack    = cyc_q & i_wb_ack;
    assign w_expire = cyc_q & ~i_wb_ack & (cnt_q == C_CNT_LAST);

    always_comb begin
        cyc_d  = cyc_q;
        stb_d  = stb_q;
        we_d   = we_q;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (!cyc_q) begin
            if (i_req) begin
                cyc_d  = 1'b1;
                stb_d  = 1'b1;
                we_d   = i_we;
                addr_d = i_addr;
                data_d = i_data;
                cnt_d  = '0;
            end
        end else if (w_ack || w_expire) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            cnt_d = '0;
        end else begin
            if (stb_q && !i_wb_stall) begin
                stb_d = 1'b0;
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            cyc_q  <= cyc_d;
            stb_q  <= stb_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_done    = w_ack;
    assign o_timeout = w_expire;
    assign o_rdata   = i_wb_data;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_stb  = stb_q;
    assign o_wb_we   = we_q;
    assign o_wb_addr = addr_q;
    assign o_wb_data = data_q;

endmodule

`default_nettype wire

// File: rtl/wb_lfsr_sequencer.sv
// ============================================================================
//  Module      : wb_lfsr_sequencer
//  Description : Configures the wb_lfsr slave, then drains it into a byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_lfsr_sequencer
    import wb_lfsr_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] ADDR_CTRL    = ADDR_CTRL_DEF,
    parameter logic [WB_ADDR_W-1:0] ADDR_SEED_LO = ADDR_SEED_LO_DEF,
    parameter logic [WB_ADDR_W-1:0] ADDR_SEED_HI = ADDR_SEED_HI_DEF,
    parameter logic [WB_ADDR_W-1:0] ADDR_TAPS_LO = ADDR_TAPS_LO_DEF,
    parameter logic [WB_ADDR_W-1:0] ADDR_TAPS_HI = ADDR_TAPS_HI_DEF,
    parameter logic [WB_ADDR_W-1:0] ADDR_OUT     = ADDR_OUT_DEF,
    parameter int                   TIMEOUT      = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [15:0]          i_seed,
    input  logic [15:0]          i_taps,
    input  logic [7:0]           i_nbytes,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [7:0]           o_byte,
    output logic                 o_byte_valid,
    input  logic                 i_byte_ready,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [WB_ADDR_W-1:0] o_wb_addr,
    output logic [WB_DATA_W-1:0] o_wb_data,
    input  logic                 i_wb_stall,
    input  logic                 i_wb_data,
    input  logic                 i_wb_ack
);

    localparam logic [2:0] C_CFG_LAST = 3'd5;

    state_e      state_q,   state_d;
    logic [15:0] seed_q,    seed_d;
    logic [15:0] taps_q,    taps_d;
    logic [7:0]  nbytes_q,  nbytes_d;
    logic [2:0]  cfg_idx_q, cfg_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  byte_q,    byte_d;
    logic        wait_q,    wait_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        err_q,     err_d;
    logic        valid_q,   valid_d;

    logic                 w_req;
    logic                 w_we;
    logic [WB_ADDR_W-1:0] w_addr;
    logic [WB_DATA_W-1:0] w_data;
    logic [WB_ADDR_W-1:0] w_cfg_addr;
    logic [WB_DATA_W-1:0] w_cfg_data;
    logic                 m_done;
    logic                 m_timeout;
    logic                 m_rdata;

    // Write sequence: disable, seed, taps, then re-enable.
    always_comb begin
        w_cfg_addr = ADDR_CTRL;
        w_cfg_data = 8'h01;
        case (cfg_idx_q)
            3'd0: begin w_cfg_addr = ADDR_CTRL;    w_cfg_data = 8'h00;         end
            3'd1: begin w_cfg_addr = ADDR_SEED_LO; w_cfg_data = seed_q[7:0];   end
            3'd2: begin w_cfg_addr = ADDR_SEED_HI; w_cfg_data = seed_q[15:8];  end
            3'd3: begin w_cfg_addr = ADDR_TAPS_LO; w_cfg_data = taps_q[7:0];   end
            3'd4: begin w_cfg_addr = ADDR_TAPS_HI; w_cfg_data = taps_q[15:8];  end
            default: begin w_cfg_addr = ADDR_CTRL; w_cfg_data = 8'h01;         end
        endcase
    end

    // wait_q clears on the ack edge, so the engine is idle for one cycle before the next request.
    assign w_req  = ((state_q == ST_CFG) || (state_q == ST_RD)) && !wait_q;
    assign w_we   = (state_q == ST_CFG);
    assign w_addr = w_we ? w_cfg_addr : ADDR_OUT;
    assign w_data = w_we ? w_cfg_data : 8'h00;

    always_comb begin
        state_d   = state_q;
        seed_d    = seed_q;
        taps_d    = taps_q;
        nbytes_d  = nbytes_q;
        cfg_idx_d = cfg_idx_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        wait_d    = wait_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_FIN, ST_ABORT: begin
                state_d = ST_IDLE;
                if (i_start) begin
                    state_d   = ST_CFG;
                    seed_d    = i_seed;
                    taps_d    = i_taps;
                    nbytes_d  = i_nbytes;
                    cfg_idx_d = 3'd0;
                    bit_cnt_d = 3'd0;
                    byte_d    = 8'h00;
                    wait_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_CFG: begin
                if (w_req) begin
                    wait_d = 1'b1;
                end
                if (m_timeout) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    wait_d  = 1'b0;
                    byte_d  = 8'h00;
                end else if (m_done) begin
                    wait_d = 1'b0;
                    if (cfg_idx_q == C_CFG_LAST) begin
                        cfg_idx_d = 3'd0;
                        if (nbytes_q == 8'd0) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_RD;
                        end
                    end else begin
                        cfg_idx_d = cfg_idx_q + 3'd1;
                    end
                end
            end
            ST_RD: begin
                if (w_req) begin
                    wait_d = 1'b1;
                end
                if (m_timeout) begin
                    state_d   = ST_ABORT;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    wait_d    = 1'b0;
                    byte_d    = 8'h00;
                    bit_cnt_d = 3'd0;
                end else if (m_done) begin
                    wait_d    = 1'b0;
                    byte_d    = shift_in_msb(byte_q, m_rdata);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d  = ST_EMIT;
                        valid_d  = 1'b1;
                        nbytes_d = nbytes_q - 8'd1;
                    end
                end
            end
            ST_EMIT: begin
                // No request is raised here, so backpressure also holds the LFSR.
                if (i_byte_ready) begin
                    valid_d = 1'b0;
                    if (nbytes_q != 8'd0) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            seed_q    <= 16'h0000;
            taps_q    <= 16'h0000;
            nbytes_q  <= 8'h00;
            cfg_idx_q <= 3'd0;
            bit_cnt_q <= 3'd0;
            byte_q    <= 8'h00;
            wait_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seed_q    <= seed_d;
            taps_q    <= taps_d;
            nbytes_q  <= nbytes_d;
            cfg_idx_q <= cfg_idx_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            wait_q    <= wait_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
        end
    end

    wb_single_master #(
        .TIMEOUT (TIMEOUT)
    ) u_master (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (w_req),
        .i_we       (w_we),
        .i_addr     (w_addr),
        .i_data     (w_data),
        .o_done     (m_done),
        .o_timeout  (m_timeout),
        .o_rdata    (m_rdata),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .i_wb_stall (i_wb_stall),
        .i_wb_data  (i_wb_data),
        .i_wb_ack   (i_wb_ack)
    );

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_byte       = byte_q;
    assign o_byte_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_lfsr_sequencer.sv
// ============================================================================
//  Module      : tb_wb_lfsr_sequencer
//  Description : Randomised bench with a Wishbone slave and transaction/byte model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_lfsr_sequencer;

    localparam int C_TIMEOUT = 16;

    logic        clk;
    logic        i_reset, i_start, i_byte_ready;
    logic [15:0] i_seed, i_taps;
    logic [7:0]  i_nbytes;
    logic        o_busy, o_done, o_err, o_byte_valid;
    logic [7:0]  o_byte;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [7:0]  o_wb_data;
    logic        i_wb_stall, i_wb_data, i_wb_ack;

    wb_lfsr_sequencer dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_seed(i_seed), .i_taps(i_taps), .i_nbytes(i_nbytes),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: expected bus transactions {we,addr,data} and bytes, plus what was observed.
    logic [11:0] exp_tx[$];
    logic [7:0]  exp_bytes[$];
    logic [11:0] got_tx[$];
    logic [7:0]  got_bytes[$];
    bit          rbits[$];

    // Slave / consumer configuration
    bit mon_en = 1'b0;
    int cfg_smin = 0, cfg_smax = 0, cfg_dly = 1, cfg_noack = -1, ready_mode = 0;
    int tx_idx = 0, hold_left = 0;
    int done_seen = 0, err_seen = 0;

    int          cycle = 0, rise_cycle = 0, s_stall_left = 0, s_wait = 0;
    bit          s_accepted = 0, s_acked = 0, s_noack = 0;
    logic        prev_cyc = 0, prev_ack = 0, prev_valid = 0;
    logic [7:0]  prev_byte = 0;
    logic [11:0] act_tx;

    initial begin
        i_wb_ack = 0; i_wb_stall = 0; i_wb_data = 0; i_byte_ready = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!mon_en) begin
                i_wb_ack = 0; i_wb_stall = 0; i_byte_ready = 0;
                prev_cyc = 0; prev_ack = 0; prev_valid = 0;
            end else begin
                if (o_wb_cyc && !prev_cyc) begin
                    rise_cycle = cycle;
                    check("cyc_stb_rise_together", o_wb_stb, 1);
                    s_accepted = 0; s_acked = 0; s_noack = 0;
                    s_stall_left = int'($urandom_range(cfg_smax, cfg_smin));
                end
                if (o_wb_stb) check("stb_within_cyc", o_wb_cyc, 1);
                if (prev_ack) check("cyc_drops_after_ack", o_wb_cyc, 0);
                if (o_wb_stb && s_accepted) check("stb_drops_after_accept", o_wb_stb, 0);
                if (o_byte_valid) check("no_bus_while_valid", o_wb_cyc, 0);
                if (o_byte_valid && prev_valid) check("byte_stable", o_byte, prev_byte);
                if (o_done) done_seen++;
                if (o_err) begin
                    err_seen++;
                    check("err_latency", cycle - rise_cycle, C_TIMEOUT);
                    check("cyc_low_at_err", o_wb_cyc, 0);
                    check("busy_low_at_err", o_busy, 0);
                end
                // Slave response for this cycle
                i_wb_ack = 0; i_wb_stall = 0; i_wb_data = 1'($urandom);
                if (o_wb_cyc) begin
                    if (o_wb_stb && !s_accepted) begin
                        if (s_stall_left > 0) begin
                            i_wb_stall = 1; s_stall_left--;
                        end else begin
                            s_accepted = 1;
                            act_tx = {o_wb_we, o_wb_addr, o_wb_we ? o_wb_data : 8'h00};
                            got_tx.push_back(act_tx);
                            if (exp_tx.size() == 0) begin
                                n_vec++; n_bad++;
                                $display("FAIL extra_tx: got 0x%0h expected none", act_tx);
                            end else begin
                                check("tx", act_tx, exp_tx.pop_front());
                            end
                            s_noack = (tx_idx == cfg_noack);
                            tx_idx++;
                            s_wait = cfg_dly;
                        end
                    end
                    if (s_accepted && !s_acked && !s_noack) begin
                        if (s_wait == 0) begin
                            i_wb_ack = 1; s_acked = 1;
                            if (!o_wb_we && rbits.size() > 0) i_wb_data = rbits.pop_front();
                        end else begin
                            s_wait--;
                        end
                    end
                end
                // Consumer
                case (ready_mode)
                    0: i_byte_ready = 1;
                    1: i_byte_ready = 1'($urandom);
                    default: begin
                        i_byte_ready = 0;
                        if (o_byte_valid) begin
                            if (hold_left > 0) hold_left--;
                            else i_byte_ready = 1;
                        end
                    end
                endcase
                if (o_byte_valid && i_byte_ready) begin
                    got_bytes.push_back(o_byte);
                    if (exp_bytes.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL extra_byte: got 0x%0h expected none", o_byte);
                    end else begin
                        check("byte", o_byte, exp_bytes.pop_front());
                    end
                end
                prev_cyc = o_wb_cyc; prev_ack = i_wb_ack;
                prev_valid = o_byte_valid; prev_byte = o_byte;
            end
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic prepare(input logic [15:0] seed, input logic [15:0] taps, input logic [7:0] nb);
        logic [7:0] v;
        exp_tx.delete(); exp_bytes.delete(); got_tx.delete(); got_bytes.delete();
        exp_tx.push_back({1'b1, 3'd0, 8'h00});
        exp_tx.push_back({1'b1, 3'd1, seed[7:0]});
        exp_tx.push_back({1'b1, 3'd2, seed[15:8]});
        exp_tx.push_back({1'b1, 3'd3, taps[7:0]});
        exp_tx.push_back({1'b1, 3'd4, taps[15:8]});
        exp_tx.push_back({1'b1, 3'd0, 8'h01});
        for (int i = 0; i < 8 * int'(nb); i++) exp_tx.push_back({1'b0, 3'd5, 8'h00});
        while (rbits.size() < 8 * int'(nb)) rbits.push_back(1'($urandom));
        for (int k = 0; k < int'(nb); k++) begin
            v = 0;
            for (int j = 0; j < 8; j++) v = v * 2 + 8'(rbits[8 * k + j]);
            exp_bytes.push_back(v);
        end
        tx_idx = 0; done_seen = 0; err_seen = 0; hold_left = 10;
    endtask

    task automatic start_pulse(input logic [15:0] seed, input logic [15:0] taps, input logic [7:0] nb);
        @(negedge clk);
        i_start = 1; i_seed = seed; i_taps = taps; i_nbytes = nb;
        tick();
        i_start = 0; i_seed = 16'($urandom); i_taps = 16'($urandom); i_nbytes = 8'($urandom);
        check("busy_after_start", o_busy, 1);
    endtask

    task automatic run(input logic [15:0] seed, input logic [15:0] taps, input logic [7:0] nb,
                       input int smin, input int smax, input int dly, input int noack, input int rmode);
        int t;
        bit exp_err;
        cfg_smin = smin; cfg_smax = smax; cfg_dly = dly; cfg_noack = noack; ready_mode = rmode;
        exp_err = (noack >= 0);
        prepare(seed, taps, nb);
        start_pulse(seed, taps, nb);
        // A start while busy must not disturb the run in progress.
        tick();
        i_start = 1; i_seed = 16'($urandom); i_taps = 16'($urandom); i_nbytes = 8'($urandom);
        tick();
        i_start = 0;
        t = 0;
        while (done_seen == 0 && err_seen == 0 && t < 4000) begin
            tick(); t++;
        end
        if (t >= 4000) begin
            n_vec++; n_bad++;
            $display("FAIL run_timeout: got no done/err expected one within 4000 cycles");
        end
        repeat (4) tick();
        check("done_pulses", done_seen, exp_err ? 0 : 1);
        check("err_pulses", err_seen, exp_err ? 1 : 0);
        check("busy_after_run", o_busy, 0);
        check("cyc_after_run", o_wb_cyc, 0);
        check("valid_after_run", o_byte_valid, 0);
        if (exp_err) begin
            check("tx_before_abort", got_tx.size(), noack + 1);
        end else begin
            check("tx_left", exp_tx.size(), 0);
            check("bytes_left", exp_bytes.size(), 0);
        end
        rbits.delete();
    endtask

    initial begin
        int t;
        i_reset = 1; i_start = 0; i_seed = 0; i_taps = 0; i_nbytes = 0;
        repeat (3) tick();
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_valid", o_byte_valid, 0);
        check("rst_byte", o_byte, 0);
        check("rst_bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}, 0);
        i_reset = 0;
        mon_en = 1;
        tick();

        // Configuration only
        run(16'hACE1, 16'hB400, 8'd0, 0, 0, 1, -1, 0);
        check("t1_tx_count", got_tx.size(), 6);
        check("t1_tx0", got_tx[0], 12'h800);
        check("t1_tx1", got_tx[1], 12'h9E1);
        check("t1_tx2", got_tx[2], 12'hAAC);
        check("t1_tx3", got_tx[3], 12'hB00);
        check("t1_tx4", got_tx[4], 12'hCB4);
        check("t1_tx5", got_tx[5], 12'h801);
        check("t1_no_bytes", got_bytes.size(), 0);

        // Two bytes from a known bit pattern
        rbits = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        run(16'hACE1, 16'hB400, 8'd2, 0, 0, 1, -1, 0);
        check("t2_tx_count", got_tx.size(), 22);
        check("t2_byte0", got_bytes[0], 8'hB2);
        check("t2_byte1", got_bytes[1], 8'hFF);

        // Three stall cycles on every operation
        run(16'h1234, 16'h8016, 8'd1, 3, 3, 1, -1, 0);
        check("t3_tx_count", got_tx.size(), 14);

        // Third write never acknowledged
        run(16'h5A5A, 16'hC000, 8'd3, 0, 0, 1, 2, 0);

        // Consumer holds off for ten cycles
        run(16'hBEEF, 16'hA001, 8'd1, 0, 1, 1, -1, 2);
        check("t5_bytes", got_bytes.size(), 1);

        // Reset in the middle of reads, with a start pulse in the same cycle
        cfg_smin = 0; cfg_smax = 0; cfg_dly = 1; cfg_noack = -1; ready_mode = 0;
        prepare(16'h0F0F, 16'hB400, 8'd3);
        start_pulse(16'h0F0F, 16'hB400, 8'd3);
        t = 0;
        while (got_tx.size() < 9 && t < 2000) begin
            tick(); t++;
        end
        if (t >= 2000) begin
            n_vec++; n_bad++;
            $display("FAIL t6_reach_reads: got %0d tx expected 9", got_tx.size());
        end
        @(negedge clk);
        mon_en = 0; i_reset = 1; i_start = 1;
        tick();
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_flags", {o_done, o_err, o_byte_valid}, 0);
        check("t6_rst_byte", o_byte, 0);
        check("t6_rst_bus", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data}, 0);
        i_reset = 0; i_start = 0;
        rbits.delete();
        tick();
        check("t6_idle_after_rst", o_busy, 0);
        mon_en = 1;
        run(16'h3C3C, 16'h9000, 8'd1, 0, 0, 1, -1, 0);
        check("t6_first_tx", got_tx[0], 12'h800);

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            run(16'($urandom), 16'($urandom), 8'($urandom_range(4, 0)),
                0, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), -1, 1);
        end
        run(16'($urandom), 16'($urandom), 8'd2, 0, 1, 0, int'($urandom_range(21, 6)), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
